lane_align_ctrl: RTL and testbench

// Per-lane word-alignment trainer for the ADC DDR capture path. Runs on dco_clk after the bitslip stage.

---
 rtl/lane_align_pkg.sv | 23 ++
 rtl/lane_align_fsm.sv | 161 ++++++++++++++++
 rtl/lane_align_ctrl.sv | 52 +++++
 tb/tb_lane_align_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_align_pkg.sv
// Shared types, default parameters and counter-width helper for the lane alignment trainer.
package lane_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

  localparam int         DEF_WORD_BITS    = 8;
  localparam logic [7:0] DEF_TRAIN_WORD   = 8'hE4;
  localparam int         DEF_SETTLE_WORDS = 2;
  localparam int         DEF_MATCH_WORDS  = 4;

  // Width needed to hold every value 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lane_align_fsm.sv
// One lane: DDR pair shift register, word counter, alignment FSM and phase-step bookkeeping.
// Optional mismatch counter while locked is built when LANE_ALIGN_ERRCNT_EN is defined.
module lane_align_fsm
  import lane_align_pkg::*;
#(
  parameter int                   WORD_BITS    = DEF_WORD_BITS,
  parameter logic [WORD_BITS-1:0] TRAIN_WORD   = WORD_BITS'(DEF_TRAIN_WORD),
  parameter int                   SETTLE_WORDS = DEF_SETTLE_WORDS,
  parameter int                   MATCH_WORDS  = DEF_MATCH_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rise,
  input  logic                 fall,
  input  logic                 train_start,
  output logic                 bitslip_pulse,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 locked,
  output logic                 fail
`ifdef LANE_ALIGN_ERRCNT_EN
  ,
  output logic [7:0]           errcnt
`endif
);

  localparam int WC_W = cnt_w(WORD_BITS / 2 - 1);
  localparam int AT_W = cnt_w(WORD_BITS);
  localparam int SC_W = cnt_w(SETTLE_WORDS);
  localparam int MC_W = cnt_w(MATCH_WORDS);

  localparam logic [WC_W-1:0] WC_LAST     = WC_W'(WORD_BITS / 2 - 1);
  localparam logic [AT_W-1:0] AT_MAX      = AT_W'(WORD_BITS);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_WORDS - 1);
  localparam logic [MC_W-1:0] MATCH_LAST  = MC_W'(MATCH_WORDS - 1);

  align_state_t state, state_next;

  logic [WORD_BITS-1:0] shift_p0;
  logic [WORD_BITS-1:0] shift_next;
  logic [WORD_BITS-1:0] word_p1;
  logic                 vld_p1;
  logic [WC_W-1:0]      wc;
  logic                 wc_hold;
  logic                 word_hit;
  logic [AT_W-1:0]      attempts;
  logic [SC_W-1:0]      settle_cnt;
  logic [MC_W-1:0]      match_cnt;
  logic                 mirror;

  assign shift_next = {shift_p0[WORD_BITS-3:0], rise, fall};
  // A slip that returns the bitslip stage to its base phase moves the data one bit
  // earlier; stalling wc one cycle moves the boundary two bits later, net +1 bit.
  assign wc_hold    = (state == ST_SLIP) && mirror;
  assign word_hit   = (word_p1 == TRAIN_WORD);

  // Stage p0: pair shift register and word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_p0 <= '0;
      wc       <= '0;
      vld_p1   <= 1'b0;
      word_p1  <= '0;
    end else begin
      shift_p0 <= shift_next;
      vld_p1   <= 1'b0;
      if (!wc_hold) begin
        if (wc == WC_LAST) begin
          wc      <= '0;
          vld_p1  <= 1'b1;
          word_p1 <= shift_next;
        end else begin
          wc <= wc + 1'b1;
        end
      end
    end
  end

  // Stage p1: registered word output consumed by the FSM
  assign word_valid = vld_p1;
  assign word_data  = word_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_SETTLE: if (vld_p1 && (settle_cnt == SETTLE_LAST)) state_next = ST_CHECK;
      ST_CHECK: begin
        if (vld_p1) begin
          if (word_hit) begin
            if (match_cnt == MATCH_LAST) state_next = ST_LOCKED;
          end else if (attempts >= AT_MAX) begin
            state_next = ST_FAIL;
          end else begin
            state_next = ST_SLIP;
          end
        end
      end
      ST_SLIP:  state_next = ST_SETTLE;
      default:  state_next = state;
    endcase
    // A start during SLIP still lets the pulse complete; SLIP exits to SETTLE anyway.
    if (train_start) state_next = ST_SETTLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      attempts   <= '0;
      settle_cnt <= '0;
      match_cnt  <= '0;
      mirror     <= 1'b0;
    end else begin
      if (state == ST_SLIP) mirror <= ~mirror;
      if (train_start) begin
        attempts   <= '0;
        settle_cnt <= '0;
        match_cnt  <= '0;
      end else begin
        case (state)
          ST_SETTLE: if (vld_p1) settle_cnt <= settle_cnt + 1'b1;
          ST_CHECK: begin
            if (vld_p1) begin
              if (word_hit) match_cnt <= match_cnt + 1'b1;
              else          match_cnt <= '0;
            end
          end
          ST_SLIP: begin
            attempts   <= attempts + 1'b1;
            settle_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bitslip_pulse = (state == ST_SLIP);
  assign locked        = (state == ST_LOCKED);
  assign fail          = (state == ST_FAIL);

`ifdef LANE_ALIGN_ERRCNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errcnt <= '0;
    end else if (train_start) begin
      errcnt <= '0;
    end else if ((state == ST_LOCKED) && vld_p1 && !word_hit) begin
      errcnt <= sat_inc(errcnt);
    end
  end
`endif

endmodule

// File: rtl/lane_align_ctrl.sv
// Multi-lane ADC word-alignment trainer on dco_clk; one independent lane_align_fsm per lane.
// Defining LANE_ALIGN_ERRCNT_EN adds the lane_errcnt port (per-lane mismatch count while locked).
module lane_align_ctrl
  import lane_align_pkg::*;
#(
  parameter int                   LANES        = 2,
  parameter int                   WORD_BITS    = DEF_WORD_BITS,
  parameter logic [WORD_BITS-1:0] TRAIN_WORD   = WORD_BITS'(DEF_TRAIN_WORD),
  parameter int                   SETTLE_WORDS = DEF_SETTLE_WORDS,
  parameter int                   MATCH_WORDS  = DEF_MATCH_WORDS
) (
  input  logic                       dco_clk,
  input  logic                       rst_n,
  input  logic [LANES-1:0]           in_rise,
  input  logic [LANES-1:0]           in_fall,
  input  logic                       train_start,
  output logic [LANES-1:0]           bitslip_pulse,
  output logic [LANES-1:0]           word_valid,
  output logic [LANES*WORD_BITS-1:0] word_data,
  output logic [LANES-1:0]           lane_locked,
  output logic [LANES-1:0]           lane_fail
`ifdef LANE_ALIGN_ERRCNT_EN
  ,
  output logic [LANES*8-1:0]         lane_errcnt
`endif
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_align_fsm #(
      .WORD_BITS   (WORD_BITS),
      .TRAIN_WORD  (TRAIN_WORD),
      .SETTLE_WORDS(SETTLE_WORDS),
      .MATCH_WORDS (MATCH_WORDS)
    ) u_lane (
      .clk          (dco_clk),
      .rst_n        (rst_n),
      .rise         (in_rise[i]),
      .fall         (in_fall[i]),
      .train_start  (train_start),
      .bitslip_pulse(bitslip_pulse[i]),
      .word_valid   (word_valid[i]),
      .word_data    (word_data[i*WORD_BITS +: WORD_BITS]),
      .locked       (lane_locked[i]),
      .fail         (lane_fail[i])
`ifdef LANE_ALIGN_ERRCNT_EN
      ,
      .errcnt       (lane_errcnt[i*8 +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_lane_align_ctrl.sv
// Bench: delayed DDR training source -> toggle-on-pulse bitslip model -> lane_align_ctrl,
// with per-lane outcome expectations queued at train_start and popped at lock/fail.
`timescale 1ns/1ps
module tb_lane_align_ctrl;

  localparam int         LANES   = 2;
  localparam int         WB      = 8;
  localparam logic [7:0] TW      = 8'hE4;
  localparam int         M_TRAIN = 0;
  localparam int         M_ZERO  = 1;
  localparam int         M_BAD   = 2;

  logic                  dco_clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  train_start = 1'b0;
  logic [LANES-1:0]      in_rise, in_fall;
  logic [LANES-1:0]      bitslip_pulse, word_valid, lane_locked, lane_fail;
  logic [LANES*WB-1:0]   word_data;
`ifdef LANE_ALIGN_ERRCNT_EN
  logic [LANES*8-1:0]    lane_errcnt;
`endif

  always #5 dco_clk = ~dco_clk;

  lane_align_ctrl dut (
    .dco_clk      (dco_clk),
    .rst_n        (rst_n),
    .in_rise      (in_rise),
    .in_fall      (in_fall),
    .train_start  (train_start),
    .bitslip_pulse(bitslip_pulse),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .lane_locked  (lane_locked),
    .lane_fail    (lane_fail)
`ifdef LANE_ALIGN_ERRCNT_EN
    ,
    .lane_errcnt  (lane_errcnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Source and bitslip model
  int   src_cnt;
  int   dly  [LANES];
  int   mode [LANES];
  logic [LANES-1:0] prev_rise, prev_fall, toggle;

  function automatic logic src_bit(input int l, input int m);
    logic [7:0] w;
    int p;
    w = (mode[l] == M_BAD) ? ~TW : TW;
    p = (m + 18 - dly[l]) % 8;
    if (mode[l] == M_ZERO) return 1'b0;
    return w[7-p];
  endfunction

  always @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      src_cnt   <= 0;
      prev_rise <= '0;
      prev_fall <= '0;
      toggle    <= '0;
    end else begin
      src_cnt <= src_cnt + 2;
      for (int l = 0; l < LANES; l++) begin
        prev_rise[l] <= src_bit(l, src_cnt);
        prev_fall[l] <= src_bit(l, src_cnt + 1);
        if (bitslip_pulse[l]) toggle[l] <= ~toggle[l];
      end
    end
  end

  // Toggled: output pair advances by one bit (previous fall, current rise).
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      in_rise[l] = toggle[l] ? prev_fall[l] : prev_rise[l];
      in_fall[l] = toggle[l] ? src_bit(l, src_cnt) : prev_fall[l];
    end
  end

  // Scoreboard
  typedef struct {
    int pulses;
    int locked;
    int fail;
    int holds;
    int words;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int   cyc = 0;
  int   words [LANES];
  logic start_q = 1'b0;

  always @(posedge dco_clk) begin
    cyc     <= cyc + 1;
    start_q <= train_start;
    for (int l = 0; l < LANES; l++) begin
      if (train_start)        words[l] <= 0;
      else if (word_valid[l]) words[l] <= words[l] + 1;
    end
  end

  int npulse [LANES];
  int nlong [LANES];
  int last_pulse [LANES];
  int last_valid [LANES];
  logic [LANES-1:0] term_q = '0;
  bit chk_words = 1'b1;

  always @(negedge dco_clk) begin
    exp_t e;
    bit   got_e;
    for (int l = 0; l < LANES; l++) begin
      if (start_q || !rst_n) begin
        npulse[l]     = 0;
        nlong[l]      = 0;
        last_pulse[l] = 0;
        last_valid[l] = -1;
      end
      if (bitslip_pulse[l]) begin
        if (npulse[l] > 0)
          chk($sformatf("L%0d_pulse_gap>=12", l), int'((cyc - last_pulse[l]) >= 12), 1);
        last_pulse[l] = cyc;
        npulse[l]++;
      end
      if (word_valid[l]) begin
        if (last_valid[l] >= 0 && (cyc - last_valid[l]) == 5) nlong[l]++;
        last_valid[l] = cyc;
        if (lane_locked[l] && chk_words)
          chk($sformatf("L%0d_word", l), int'(word_data[l*WB +: WB]), int'(TW));
      end
      if ((lane_locked[l] || lane_fail[l]) && !term_q[l]) begin
        got_e = 1'b0;
        if (l == 0 && q0.size() > 0) begin e = q0.pop_front(); got_e = 1'b1; end
        if (l == 1 && q1.size() > 0) begin e = q1.pop_front(); got_e = 1'b1; end
        if (got_e) begin
          chk($sformatf("L%0d_pulses", l), npulse[l], e.pulses);
          chk($sformatf("L%0d_locked", l), int'(lane_locked[l]), e.locked);
          chk($sformatf("L%0d_fail", l), int'(lane_fail[l]), e.fail);
          chk($sformatf("L%0d_wc_holds", l), nlong[l], e.holds);
          if (e.words >= 0) chk($sformatf("L%0d_lock_words", l), words[l], e.words);
        end
      end
      term_q[l] = lane_locked[l] || lane_fail[l];
    end
  end

  task automatic pulse_start();
    @(negedge dco_clk);
    train_start = 1'b1;
    @(negedge dco_clk);
    train_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge dco_clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge dco_clk);
      chk("rst_pulse", int'(bitslip_pulse), 0);
      chk("rst_valid", int'(word_valid), 0);
      chk("rst_data", int'(word_data), 0);
      chk("rst_locked", int'(lane_locked), 0);
      chk("rst_fail", int'(lane_fail), 0);
    end
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    repeat (6) @(negedge dco_clk);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      @(negedge dco_clk);
      n++;
    end
    chk("done_timeout", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic run_train(input int d0, input int d1, input int m0, input int m1,
                           input int p0, input int p1, input int lk0, input int lk1);
    exp_t e;
    int   n0, n1;
    @(negedge dco_clk);
    dly[0] = d0; dly[1] = d1; mode[0] = m0; mode[1] = m1;
    e.pulses = p0; e.locked = lk0; e.fail = lk0 ? 0 : 1; e.holds = p0 / 2;
    e.words = (p0 == 0) ? 6 : -1;
    q0.push_back(e);
    e.pulses = p1; e.locked = lk1; e.fail = lk1 ? 0 : 1; e.holds = p1 / 2;
    e.words = (p1 == 0) ? 6 : -1;
    q1.push_back(e);
    pulse_start();
    wait_done(2000);
    n0 = npulse[0];
    n1 = npulse[1];
    repeat (60) @(negedge dco_clk);
    chk("L0_no_extra_pulse", npulse[0], n0);
    chk("L1_no_extra_pulse", npulse[1], n1);
  endtask

  initial begin
    int n;
    dly[0] = 0; dly[1] = 0;
    mode[0] = M_TRAIN; mode[1] = M_TRAIN;
    repeat (2) @(negedge dco_clk);
    do_reset();

    // Aligned source: no slips, lock after 6 words
    run_train(0, 0, M_TRAIN, M_TRAIN, 0, 0, 1, 1);

    // Lane0 delayed 3 bits
    do_reset();
    run_train(3, 0, M_TRAIN, M_TRAIN, 3, 0, 1, 1);

    // Lane0 delayed 6 bits: three wc stalls
    do_reset();
    run_train(6, 0, M_TRAIN, M_TRAIN, 6, 0, 1, 1);

    // Constant zero on lane0: exhausts all phases
    do_reset();
    run_train(0, 0, M_ZERO, M_TRAIN, 8, 0, 0, 1);
    chk("L0_fail_held", int'(lane_fail[0]), 1);
    chk("L0_not_locked", int'(lane_locked[0]), 0);
    pulse_start();
    chk("L0_fail_cleared", int'(lane_fail[0]), 0);
    chk("L1_lock_cleared", int'(lane_locked[1]), 0);

    // Reset mid-training after two slips, then retrain
    do_reset();
    dly[0] = 3; dly[1] = 0; mode[0] = M_TRAIN; mode[1] = M_TRAIN;
    pulse_start();
    n = 0;
    while (npulse[0] < 2 && n < 500) begin
      @(negedge dco_clk);
      n++;
    end
    chk("two_slips_seen", npulse[0], 2);
    repeat (3) @(negedge dco_clk);
    do_reset();
    run_train(3, 0, M_TRAIN, M_TRAIN, 3, 0, 1, 1);

`ifdef LANE_ALIGN_ERRCNT_EN
    do_reset();
    run_train(0, 0, M_TRAIN, M_TRAIN, 0, 0, 1, 1);
    chk("errcnt_start", int'(lane_errcnt[7:0]), 0);
    chk_words = 1'b0;
    mode[0] = M_BAD;
    repeat (300 * 4 + 40) @(negedge dco_clk);
    chk("errcnt_sat", int'(lane_errcnt[7:0]), 255);
    chk("errcnt_lock_kept", int'(lane_locked[0]), 1);
    chk("errcnt_l1_clean", int'(lane_errcnt[15:8]), 0);
    mode[0] = M_TRAIN;
    pulse_start();
    chk("errcnt_cleared", int'(lane_errcnt[7:0]), 0);
    repeat (60) @(negedge dco_clk);
    chk_words = 1'b1;
`endif

    repeat (5) @(negedge dco_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
